// File: rtl/serial_neg_pkg.sv
// ============================================================================
// serial_neg_pkg
// Shared mode encodings, FSM state type and counter-width helper.
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_neg_pkg;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_ONES = 2'd1;
  localparam logic [1:0] MODE_TWOS = 2'd2;
  localparam logic [1:0] MODE_INC  = 2'd3;

  // PRE is SEEK (TWOS) or CARRY (INC); POST is INVERT or COPY.
  typedef enum logic {
    ST_PRE  = 1'b0,
    ST_POST = 1'b1
  } seen_e;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_word_framer.sv
// ============================================================================
// serial_word_framer
// Bit-position counter for W-bit serial words with sync resynchronisation.
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_word_framer
  import serial_neg_pkg::*;
#(
  parameter  int W  = 8,
  localparam int CW = cnt_width(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid_i,
  input  logic          sync_i,
  output logic [CW-1:0] pos_o,
  output logic          first_o,
  output logic          last_o
);

  localparam logic [CW-1:0] C_LAST = CW'(W - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] w_pos;

  always_comb begin
    w_pos   = (sync_i && in_valid_i) ? '0 : cnt_q;
    cnt_d   = cnt_q;
    if (in_valid_i) begin
      cnt_d = (w_pos == C_LAST) ? '0 : w_pos + CW'(1);
    end
    pos_o   = w_pos;
    first_o = in_valid_i && (w_pos == '0);
    last_o  = in_valid_i && (w_pos == C_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_word_negator.sv
// ============================================================================
// serial_word_negator
// LSB-first serial PASS / ONES / TWOS / INC converter with overflow flag.
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_word_negator
  import serial_neg_pkg::*;
#(
  parameter int W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  input  logic       in_valid,
  input  logic       sync,
  input  logic [1:0] mode,
  output logic       out,
  output logic       out_valid,
  output logic       out_last,
  output logic       ovf
);

  localparam int CW = cnt_width(W);

  logic [CW-1:0] w_pos;
  logic          w_first;
  logic          w_last;

  serial_word_framer #(.W(W)) u_framer (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (in_valid),
    .sync_i     (sync),
    .pos_o      (w_pos),
    .first_o    (w_first),
    .last_o     (w_last)
  );

  logic [1:0] mode_q, mode_d;
  seen_e      seen_q, seen_d;
  logic       prefix_q, prefix_d;

  logic [1:0] w_mode;
  seen_e      w_seen, w_seen_n;
  logic       w_prefix, w_prefix_n;
  logic       w_bit, w_ovf_raw, w_act;

  always_comb begin
    // At bit 0 the word-scoped state restarts before this bit is evaluated.
    w_mode     = w_first ? mode : mode_q;
    w_seen     = w_first ? ST_PRE : seen_q;
    w_prefix   = w_first | prefix_q;
    w_bit      = in;
    w_seen_n   = w_seen;
    w_prefix_n = w_prefix;
    w_ovf_raw  = 1'b0;
    case (w_mode)
      MODE_PASS: w_bit = in;
      MODE_ONES: w_bit = ~in;
      MODE_TWOS: begin
        w_bit      = (w_seen == ST_POST) ? ~in : in;
        w_seen_n   = in ? ST_POST : w_seen;
        w_prefix_n = w_prefix & ~in;
        w_ovf_raw  = w_prefix & in;
      end
      MODE_INC: begin
        w_bit      = (w_seen == ST_PRE) ? ~in : in;
        w_seen_n   = in ? w_seen : ST_POST;
        w_prefix_n = w_prefix & in;
        w_ovf_raw  = w_prefix & ~in;
      end
      default: w_bit = in;
    endcase

    mode_d   = w_first ? mode : mode_q;
    seen_d   = in_valid ? w_seen_n : seen_q;
    prefix_d = in_valid ? w_prefix_n : prefix_q;

    // Outputs are forced quiet while reset is asserted, not just after it.
    w_act     = in_valid && !reset;
    out       = w_act && w_bit;
    out_valid = w_act;
    out_last  = w_act && w_last;
    ovf       = w_act && w_last && w_ovf_raw;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q   <= MODE_PASS;
      seen_q   <= ST_PRE;
      prefix_q <= 1'b1;
    end else begin
      mode_q   <= mode_d;
      seen_q   <= seen_d;
      prefix_q <= prefix_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_word_negator.sv
// ============================================================================
// tb_serial_word_negator
// Scoreboard bench: word-level arithmetic model vs. serial DUT output.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_word_negator;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       in;
  logic       in_valid;
  logic       sync;
  logic [1:0] mode;
  logic       out;
  logic       out_valid;
  logic       out_last;
  logic       ovf;

  serial_word_negator #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .in_valid  (in_valid),
    .sync      (sync),
    .mode      (mode),
    .out       (out),
    .out_valid (out_valid),
    .out_last  (out_last),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic o;
    logic l;
    logic v;
  } exp_t;

  exp_t exp_q[$];
  int   ncmp = 0;
  int   nerr = 0;

  function automatic logic [W-1:0] xform(input logic [W-1:0] x, input logic [1:0] m);
    logic [W-1:0] r;
    case (m)
      2'd0:    r = x;
      2'd1:    r = ~x;
      2'd2:    r = '0 - x;
      default: r = x + 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic ovf_of(input logic [W-1:0] x, input logic [1:0] m);
    logic [W-1:0] minv;
    minv = '0;
    minv[W-1] = 1'b1;
    if (m == 2'd2) return x == minv;
    if (m == 2'd3) return x == ~minv;
    return 1'b0;
  endfunction

  // Monitor: pops the scoreboard on every presented output bit.
  always @(negedge clk) begin
    exp_t e;
    logic ev;
    ev = in_valid && !reset;
    ncmp++;
    if (out_valid !== ev) begin
      nerr++;
      $display("FAIL out_valid: got %b expected %b at %0t", out_valid, ev, $time);
    end
    if (ev) begin
      ncmp++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_output: got out=%b with empty scoreboard at %0t", out, $time);
      end else begin
        e = exp_q.pop_front();
        if ({out, out_last, ovf} !== {e.o, e.l, e.v}) begin
          nerr++;
          $display("FAIL bit: got out/last/ovf=%b%b%b expected %b%b%b at %0t",
                   out, out_last, ovf, e.o, e.l, e.v, $time);
        end
      end
    end else begin
      ncmp++;
      if ({out, out_last, ovf} !== 3'b000) begin
        nerr++;
        $display("FAIL idle_quiet: got out/last/ovf=%b%b%b expected 000 at %0t",
                 out, out_last, ovf, $time);
      end
    end
  end

  task automatic gap(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in       = 1'($urandom);
      sync     = 1'($urandom);
      mode     = 2'($urandom);
    end
  endtask

  // gmode: 0 none, 1 random gaps, 2 two-cycle gaps after bits 2 and 5.
  task automatic send_word(input logic [W-1:0] x, input logic [1:0] m,
                           input int nbits, input bit sy, input int gmode);
    logic [W-1:0] fx;
    logic         ov;
    exp_t         e;
    fx = xform(x, m);
    ov = ovf_of(x, m);
    for (int i = 0; i < nbits; i++) begin
      if (gmode == 1 && ($urandom % 4) == 0) gap(int'($urandom_range(1, 3)));
      if (gmode == 2 && (i == 3 || i == 6)) gap(2);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in       = x[i];
      sync     = (i == 0) && sy;
      mode     = (i == 0) ? m : 2'($urandom);
      e.o = fx[i];
      e.l = (nbits == W) && (i == W - 1);
      e.v = e.l && ov;
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in       = 1'($urandom);
      sync     = 1'($urandom);
      @(posedge clk); #1;
    end
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    bit           pend;
    int           nb;
    logic [W-1:0] x;
    logic [1:0]   m;
    reset    = 1'b1;
    in       = 1'b1;
    in_valid = 1'b1;
    sync     = 1'b0;
    mode     = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;

    send_word(8'hE8, 2'd2, W, 1'b0, 0);
    send_word(8'h80, 2'd2, W, 1'b0, 0);
    send_word(8'h01, 2'd2, W, 1'b0, 0);
    send_word(8'h7F, 2'd3, W, 1'b0, 0);
    send_word(8'hFF, 2'd3, W, 1'b0, 0);
    send_word(8'hA5, 2'd1, W, 1'b0, 0);
    send_word(8'h3C, 2'd0, W, 1'b0, 0);
    send_word(8'hE8, 2'd2, W, 1'b0, 2);
    send_word(8'h5B, 2'd2, 4, 1'b0, 0);
    send_word(8'h2D, 2'd2, W, 1'b1, 0);
    send_word(8'hC8, 2'd2, 4, 1'b0, 0);
    pulse_reset(2);
    send_word(8'h02, 2'd2, W, 1'b0, 0);

    pend = 1'b0;
    for (int n = 0; n < 300; n++) begin
      m = 2'($urandom);
      case ($urandom % 6)
        0:       x = 8'h80;
        1:       x = 8'h7F;
        default: x = 8'($urandom);
      endcase
      nb = (($urandom % 8) == 0) ? int'($urandom_range(1, W - 1)) : W;
      send_word(x, m, nb, pend || (($urandom % 5) == 0), int'($urandom % 2));
      pend = (nb != W);
    end
    if (pend) send_word(8'h00, 2'd0, W, 1'b1, 0);

    gap(3);
    ncmp++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
